divisor_tick_scheduler: RTL and testbench

//  Multi-channel timebase scheduler sharing one prescaler among N_CH channels.

---
 rtl/divisor_tick_scheduler_pkg.sv | 25 ++
 rtl/divisor_tick_scheduler_channel.sv | 78 +++++++
 rtl/divisor_tick_scheduler.sv | 105 ++++++++++
 tb/tb_divisor_tick_scheduler.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/divisor_tick_scheduler_pkg.sv
// Shared types and defaults for the multi-channel divisor tick scheduler.
package divisor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int DEF_N_CH    = 4;
    localparam int DEF_CW      = 20;
    localparam int DEF_PRE_DIV = 50000;
    localparam int DEF_DIV_VAL = 10;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/divisor_tick_scheduler_channel.sv
// One scheduler channel: divide counter, active/shadow ratio pair, tick pulse and square wave.
module divisor_tick_channel
    import divisor_pkg::*;
#(
    parameter int CW      = DEF_CW,
    parameter int DEF_DIV = DEF_DIV_VAL
)(
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_base_tick,
    input  logic          i_en,
    input  logic          i_sync,
    input  logic          i_clear,
    input  logic          i_wr,
    input  logic [CW-1:0] i_wr_div,
    output logic          o_tick,
    output logic          o_sq,
    output logic          o_pending
);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_div;
    logic [CW-1:0] r_shadow;
    logic          r_pend;
    logic          r_tick;
    logic          r_sq;
    logic          w_step;
    logic          w_wrap;
    logic          w_apply;

    // A zero ratio would never wrap, so it is treated as the fastest legal ratio.
    function automatic logic [CW-1:0] sat_div(input logic [CW-1:0] d);
        return (d == '0) ? CW'(1) : d;
    endfunction

    assign w_step  = i_base_tick && i_en && !i_clear && !i_sync;
    assign w_wrap  = w_step && (r_cnt == r_div - CW'(1));
    assign w_apply = r_pend && (w_wrap || (i_sync && !i_clear));

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_cnt  <= '0;
            r_div  <= CW'(DEF_DIV);
            r_pend <= 1'b0;
            r_tick <= 1'b0;
            r_sq   <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (i_clear) begin
                r_cnt <= '0;
                r_sq  <= 1'b0;
            end else if (i_sync) begin
                r_cnt <= '0;
            end else if (w_wrap) begin
                r_cnt  <= '0;
                r_tick <= 1'b1;
                r_sq   <= ~r_sq;
            end else if (w_step) begin
                r_cnt <= r_cnt + CW'(1);
            end

            if (w_apply) r_div <= r_shadow;

            // A write is only accepted while nothing is pending, so it never collides with w_apply.
            if (i_wr)         r_pend <= 1'b1;
            else if (w_apply) r_pend <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_wr) r_shadow <= sat_div(i_wr_div);
    end

    assign o_tick    = r_tick;
    assign o_sq      = r_sq;
    assign o_pending = r_pend;

endmodule

// File: rtl/divisor_tick_scheduler.sv
// Multi-channel timebase scheduler: shared prescaler, run/sync FSM and config decode.
module divisor_tick_scheduler
    import divisor_pkg::*;
#(
    parameter  int N_CH    = DEF_N_CH,
    parameter  int CW      = DEF_CW,
    parameter  int PRE_DIV = DEF_PRE_DIV,
    parameter  int DEF_DIV = DEF_DIV_VAL,
    localparam int CHW     = (N_CH > 1) ? clog2(N_CH) : 1
)(
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic [N_CH-1:0] ch_en,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [CHW-1:0]  cfg_ch,
    input  logic [CW-1:0]   cfg_div,
    output logic [N_CH-1:0] tick_o,
    output logic [N_CH-1:0] sq_o,
    output logic            busy
);

    localparam int            PW       = clog2(PRE_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRE_DIV - 1);

    state_t          r_state;
    logic [PW-1:0]   r_pre;
    logic            w_base_tick;
    logic            w_sync;
    logic            w_clear;
    logic            w_sel_pend;
    logic [N_CH-1:0] w_pend;
    logic [N_CH-1:0] w_wr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_pre   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_pre <= '0;
                    if (run) r_state <= SYNC;
                end
                SYNC: begin
                    r_pre   <= '0;
                    r_state <= RUN;
                end
                RUN: begin
                    if (!run) begin
                        r_pre   <= '0;
                        r_state <= IDLE;
                    end else if (r_pre == PRE_LAST) begin
                        r_pre <= '0;
                    end else begin
                        r_pre <= r_pre + PW'(1);
                    end
                end
                default: begin
                    r_pre   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // The base tick is suppressed in the cycle run drops so no channel wraps on the way out.
    assign w_base_tick = (r_state == RUN) && run && (r_pre == PRE_LAST);
    assign w_sync      = (r_state == SYNC);
    assign w_clear     = (r_state == IDLE);
    assign busy        = (r_state != IDLE);

    // An out-of-range channel index matches nothing: it reads as ready and the write is dropped.
    always_comb begin
        w_sel_pend = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (cfg_ch == CHW'(i)) w_sel_pend = w_pend[i];
        end
    end

    assign cfg_ready = !w_sel_pend;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign w_wr[g] = cfg_valid && cfg_ready && (cfg_ch == CHW'(g));

        divisor_tick_channel #(
            .CW      (CW),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .i_clk       (clk),
            .i_reset     (reset),
            .i_base_tick (w_base_tick),
            .i_en        (ch_en[g]),
            .i_sync      (w_sync),
            .i_clear     (w_clear),
            .i_wr        (w_wr[g]),
            .i_wr_div    (cfg_div),
            .o_tick      (tick_o[g]),
            .o_sq        (sq_o[g]),
            .o_pending   (w_pend[g])
        );
    end

endmodule

// File: tb/tb_divisor_tick_scheduler.sv
// Directed bench for divisor_tick_scheduler with PRE_DIV=4, CW=8, N_CH=4, DEF_DIV=3.
module tb_divisor_tick_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic [3:0] ch_en;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic [3:0] tick_o;
    logic [3:0] sq_o;
    logic       busy;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic       rst_n;
        logic       run;
        logic [3:0] en;
        int         adv;
        logic [3:0] tick;
        logic [3:0] sq;
        logic       busy;
    } vec_t;

    vec_t vecs[11];

    always #5 clk = ~clk;

    divisor_tick_scheduler #(
        .N_CH    (4),
        .CW      (8),
        .PRE_DIV (4),
        .DEF_DIV (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .ch_en     (ch_en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .tick_o    (tick_o),
        .sq_o      (sq_o),
        .busy      (busy)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Advance until tick_o[ch] is seen; n is the number of edges taken, -1 on timeout.
    task automatic wait_tick(input int ch, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (tick_o[ch] !== 1'b1 && n < 40);
        if (tick_o[ch] !== 1'b1) n = -1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int bad;

        vecs[0]  = '{1'b0, 1'b0, 4'h0,  1, 4'h0, 4'h0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 4'h0,  1, 4'h0, 4'h0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 4'h0,  1, 4'h0, 4'h0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 4'hF,  1, 4'h0, 4'h0, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 4'hF,  1, 4'h0, 4'h0, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 4'hF, 11, 4'h0, 4'h0, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 4'hF,  1, 4'hF, 4'hF, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 4'hF,  1, 4'h0, 4'hF, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 4'hF, 10, 4'h0, 4'hF, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 4'hF,  1, 4'hF, 4'h0, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 4'hF,  1, 4'h0, 4'h0, 1'b1};

        reset = 1'b0; run = 1'b0; ch_en = 4'h0;
        cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_div = 8'd0;

        // Reset, start-up and the default 12-cycle tick / 24-cycle square wave.
        for (int i = 0; i < 11; i++) begin
            reset = vecs[i].rst_n;
            run   = vecs[i].run;
            ch_en = vecs[i].en;
            repeat (vecs[i].adv) cyc();
            check($sformatf("v%0d_tick", i), tick_o, vecs[i].tick);
            check($sformatf("v%0d_sq", i), sq_o, vecs[i].sq);
            check($sformatf("v%0d_busy", i), busy, vecs[i].busy);
            check($sformatf("v%0d_ready", i), cfg_ready, 1'b1);
        end

        // ch1 div=0 coerced to 1; applied at ch1's next wrap.
        cfg_ch = 2'd1; cfg_div = 8'd0; cfg_valid = 1'b1;
        check("cfg1_ready", cfg_ready, 1'b1);
        cyc();
        cfg_valid = 1'b0;
        check("cfg1_pending", cfg_ready, 1'b0);
        wait_tick(1, n); check("ch1_old_wrap", n, 10);
        check("cfg1_applied", cfg_ready, 1'b1);
        wait_tick(1, n); check("ch1_div1_a", n, 4);
        wait_tick(1, n); check("ch1_div1_b", n, 4);
        wait_tick(0, n); check("ch0_phase", n, 4);
        wait_tick(0, n); check("ch0_period", n, 12);

        // ch2 div=5 accepted on ch2's wrap edge, second write refused while pending.
        repeat (11) cyc();
        cfg_ch = 2'd2; cfg_div = 8'd5; cfg_valid = 1'b1;
        check("cfg2_ready", cfg_ready, 1'b1);
        cyc();
        check("ch2_wrap_edge", tick_o[2], 1'b1);
        cfg_div = 8'd7;
        check("cfg2_busy_a", cfg_ready, 1'b0);
        cyc();
        check("cfg2_busy_b", cfg_ready, 1'b0);
        cfg_valid = 1'b0;
        wait_tick(2, n); check("ch2_still3", n, 11);
        wait_tick(2, n); check("ch2_div5_a", n, 20);
        wait_tick(2, n); check("ch2_div5_b", n, 20);
        check("cfg2_free", cfg_ready, 1'b1);

        // ch3 disabled for 30 cycles with count=1 and sq=1, then resumes.
        repeat (12) cyc();
        ch_en = 4'h7;
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            cyc();
            if (tick_o[3] !== 1'b0 || sq_o[3] !== 1'b1) bad++;
        end
        check("ch3_frozen", bad, 0);
        ch_en = 4'hF;
        wait_tick(3, n); check("ch3_resume", n, 6);
        check("ch3_sq_after", sq_o[3], 1'b0);
        wait_tick(3, n); check("ch3_period", n, 12);

        // run dropped on a base-tick edge, ch0 reprogrammed in IDLE, restart.
        repeat (3) cyc();
        run = 1'b0;
        cyc();
        check("stop_tick", tick_o, 4'h0);
        check("stop_busy", busy, 1'b0);
        cyc();
        check("idle_sq", sq_o, 4'h0);
        cfg_ch = 2'd0; cfg_div = 8'd2; cfg_valid = 1'b1;
        check("cfg0_ready", cfg_ready, 1'b1);
        cyc();
        cfg_valid = 1'b0;
        check("cfg0_pending", cfg_ready, 1'b0);
        run = 1'b1;
        cyc();
        check("sync_busy", busy, 1'b1);
        cyc();
        check("sync_applied", cfg_ready, 1'b1);
        wait_tick(0, n); check("ch0_div2_first", n, 8);
        check("ch0_sq_first", sq_o[0], 1'b1);
        wait_tick(0, n); check("ch0_div2_period", n, 8);

        // Reset in RUN with a pending write: everything returns to defaults.
        cfg_ch = 2'd1; cfg_div = 8'd6; cfg_valid = 1'b1;
        check("cfg6_ready", cfg_ready, 1'b1);
        cyc();
        cfg_valid = 1'b0;
        check("cfg6_pending", cfg_ready, 1'b0);
        reset = 1'b0;
        cyc();
        check("rst_tick", tick_o, 4'h0);
        check("rst_sq", sq_o, 4'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", cfg_ready, 1'b1);
        reset = 1'b1;
        cyc();
        cyc();
        wait_tick(1, n); check("rst_ch1_default", n, 12);
        check("rst_all_aligned", tick_o, 4'hF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
